rob_multiport: RTL

Parametrised reorder buffer, next generation of the 8-entry core ROB. Circular buffer with NUM_WB independent write-back ports (short pipeline, long f_stages pipeline, extra units) and in-order single retire into the register bank. Adds full back-pressure, an occupancy count, precise exception flush with a one-cycle FLUSH state, and two ticket-indexed bypass read ports for decode.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_wb_arbiter.sv | 28 ++
 rtl/rob_multiport.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the multi-port reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DATA_W     = 16;
  localparam int unsigned ROB_REG_ADDR_W = 3;
  localparam int unsigned ROB_PC_W       = 16;
  localparam int unsigned ROB_EXC_W      = 2;

  localparam logic [ROB_EXC_W-1:0] EXC_NONE = '0;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  typedef struct packed {
    logic                      alloc;
    logic                      done;
    logic                      we;
    logic [ROB_REG_ADDR_W-1:0] dest;
    logic [ROB_DATA_W-1:0]     data;
    logic [ROB_PC_W-1:0]       pc;
    logic [ROB_EXC_W-1:0]      exc;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-slot selection of the write-back port; the lowest port index wins a tie.
module rob_wb_arbiter #(
  parameter int unsigned NUM_WB      = 2,
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned LOG_ENTRIES = 3,
  parameter int unsigned PORT_W      = 1
) (
  input  logic [NUM_WB-1:0]                  wb_valid,
  input  logic [NUM_WB*LOG_ENTRIES-1:0]      wb_ticket,
  output logic [NUM_ENTRIES-1:0]             sel_valid,
  output logic [NUM_ENTRIES-1:0][PORT_W-1:0] sel_port
);

  // Scan from the highest port down so the lowest matching port is written last.
  always_comb begin
    sel_valid = '0;
    sel_port  = '0;
    for (int s = 0; s < NUM_ENTRIES; s++) begin
      for (int i = NUM_WB - 1; i >= 0; i--) begin
        if (wb_valid[i] && (wb_ticket[i*LOG_ENTRIES +: LOG_ENTRIES] == LOG_ENTRIES'(s))) begin
          sel_valid[s] = 1'b1;
          sel_port[s]  = PORT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer with NUM_WB write-back ports, in-order single retire,
// precise exception flush and two ticket-indexed bypass read ports.
module rob_multiport import rob_pkg::*; #(
  parameter int unsigned DATA_W      = ROB_DATA_W,
  parameter int unsigned REG_ADDR_W  = ROB_REG_ADDR_W,
  parameter int unsigned PC_W        = ROB_PC_W,
  parameter int unsigned EXC_W       = ROB_EXC_W,
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned LOG_ENTRIES = 3,
  parameter int unsigned NUM_WB      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  output logic [LOG_ENTRIES-1:0]       alloc_ticket,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*LOG_ENTRIES-1:0] wb_ticket,
  input  logic [NUM_WB*DATA_W-1:0]     wb_data,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_dest,
  input  logic [NUM_WB-1:0]            wb_we,
  input  logic [NUM_WB*PC_W-1:0]       wb_pc,
  input  logic [NUM_WB*EXC_W-1:0]      wb_exc,
  input  logic [LOG_ENTRIES-1:0]       rd_ticket_a,
  input  logic [LOG_ENTRIES-1:0]       rd_ticket_b,
  output logic                         rd_ready_a,
  output logic                         rd_ready_b,
  output logic [DATA_W-1:0]            rd_data_a,
  output logic [DATA_W-1:0]            rd_data_b,
  output logic                         commit_valid,
  output logic                         commit_we,
  output logic [REG_ADDR_W-1:0]        commit_dest,
  output logic [DATA_W-1:0]            commit_data,
  output logic                         exc_valid,
  output logic [PC_W-1:0]              exc_pc,
  output logic [EXC_W-1:0]             exc_vector,
  output logic                         flush,
  output logic                         empty,
  output logic                         full,
  output logic [LOG_ENTRIES:0]         count
);

  localparam int unsigned PORT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int unsigned CNT_W  = LOG_ENTRIES + 1;

  rob_entry_t                        entries [NUM_ENTRIES];
  rob_entry_t                        head_e;
  logic                              state, state_next;
  logic [LOG_ENTRIES-1:0]            head, tail;
  logic                              alloc_fire, retire, exc_take;
  logic [NUM_ENTRIES-1:0]            sel_valid;
  logic [NUM_ENTRIES-1:0][PORT_W-1:0] sel_port;

  logic                  port_we   [NUM_WB];
  logic [REG_ADDR_W-1:0] port_dest [NUM_WB];
  logic [DATA_W-1:0]     port_data [NUM_WB];
  logic [PC_W-1:0]       port_pc   [NUM_WB];
  logic [EXC_W-1:0]      port_exc  [NUM_WB];

  // Unpack the flattened write-back buses into per-port fields.
  always_comb begin
    for (int i = 0; i < NUM_WB; i++) begin
      port_we[i]   = wb_we[i];
      port_dest[i] = wb_dest[i*REG_ADDR_W +: REG_ADDR_W];
      port_data[i] = wb_data[i*DATA_W +: DATA_W];
      port_pc[i]   = wb_pc[i*PC_W +: PC_W];
      port_exc[i]  = wb_exc[i*EXC_W +: EXC_W];
    end
  end

  rob_wb_arbiter #(
    .NUM_WB      (NUM_WB),
    .NUM_ENTRIES (NUM_ENTRIES),
    .LOG_ENTRIES (LOG_ENTRIES),
    .PORT_W      (PORT_W)
  ) u_arb (
    .wb_valid  (wb_valid),
    .wb_ticket (wb_ticket),
    .sel_valid (sel_valid),
    .sel_port  (sel_port)
  );

  assign head_e       = entries[head];
  assign full         = (count == CNT_W'(NUM_ENTRIES));
  assign empty        = (count == '0);
  assign alloc_ready  = (state == ST_RUN) && !full;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_ticket = tail;
  assign retire       = (state == ST_RUN) && head_e.alloc && head_e.done && (head_e.exc == EXC_NONE);
  assign exc_take     = (state == ST_RUN) && head_e.alloc && head_e.done && (head_e.exc != EXC_NONE);

  assign rd_ready_a = entries[rd_ticket_a].alloc && entries[rd_ticket_a].done;
  assign rd_ready_b = entries[rd_ticket_b].alloc && entries[rd_ticket_b].done;
  assign rd_data_a  = entries[rd_ticket_a].data;
  assign rd_data_b  = entries[rd_ticket_b].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // FLUSH is a single dead cycle after an exception retires.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (exc_take) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Entry storage: write-back first, then alloc and retire override their slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_ENTRIES; s++) entries[s] <= '0;
    end else if (exc_take) begin
      for (int s = 0; s < NUM_ENTRIES; s++) begin
        entries[s].alloc <= 1'b0;
        entries[s].done  <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NUM_ENTRIES; s++) begin
        if ((state == ST_RUN) && sel_valid[s] && entries[s].alloc &&
            !(alloc_fire && (tail == LOG_ENTRIES'(s)))) begin
          entries[s].done <= 1'b1;
          entries[s].we   <= port_we[sel_port[s]];
          entries[s].dest <= port_dest[sel_port[s]];
          entries[s].data <= port_data[sel_port[s]];
          entries[s].pc   <= port_pc[sel_port[s]];
          entries[s].exc  <= port_exc[sel_port[s]];
        end
      end
      if (alloc_fire) begin
        entries[tail].alloc <= 1'b1;
        entries[tail].done  <= 1'b0;
      end
      if (retire) begin
        entries[head].alloc <= 1'b0;
        entries[head].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (exc_take) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) tail <= tail + LOG_ENTRIES'(1);
      if (retire)     head <= head + LOG_ENTRIES'(1);
      case ({alloc_fire, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered retire and exception reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_dest  <= '0;
      commit_data  <= '0;
      exc_valid    <= 1'b0;
      flush        <= 1'b0;
      exc_pc       <= '0;
      exc_vector   <= '0;
    end else begin
      commit_valid <= retire;
      commit_we    <= retire && head_e.we;
      if (retire) begin
        commit_dest <= head_e.dest;
        commit_data <= head_e.data;
      end
      exc_valid <= exc_take;
      flush     <= exc_take;
      if (exc_take) begin
        exc_pc     <= head_e.pc;
        exc_vector <= head_e.exc;
      end
    end
  end

endmodule
